// File: rtl/sc_game_status_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : sc_game_status_tracker_if
// Purpose  : Strobe/flag bundle between the game state machine (master) and
//            the game status tracker datapath (slave).
// Signals  : CLEAR_InLow, ClearLost_InLow, LifesSignal_InBUS[1:0],
//            TransitionCounter1_InLow, TRANSITIONTIME_InLow  (FSM -> tracker)
//            LifesZero_OutLow, WIN_OutLow, TransitionDone_OutLow,
//            Lives_OutBUS[LIFE_W], Level_OutBUS[LEVEL_W]      (tracker -> FSM)
// Revision : 1.0 - initial release
// ============================================================================
interface sc_game_status_tracker_if #(
    parameter int LIFE_W  = 3,
    parameter int LEVEL_W = 3
);
    logic               SC_GAMESTATUS_CLEAR_InLow;
    logic               SC_GAMESTATUS_ClearLost_InLow;
    logic [1:0]         SC_GAMESTATUS_LifesSignal_InBUS;
    logic               SC_GAMESTATUS_TransitionCounter1_InLow;
    logic               SC_GAMESTATUS_TRANSITIONTIME_InLow;
    logic               SC_GAMESTATUS_LifesZero_OutLow;
    logic               SC_GAMESTATUS_WIN_OutLow;
    logic               SC_GAMESTATUS_TransitionDone_OutLow;
    logic [LIFE_W-1:0]  SC_GAMESTATUS_Lives_OutBUS;
    logic [LEVEL_W-1:0] SC_GAMESTATUS_Level_OutBUS;

    // FSM side
    modport master (
        output SC_GAMESTATUS_CLEAR_InLow,
        output SC_GAMESTATUS_ClearLost_InLow,
        output SC_GAMESTATUS_LifesSignal_InBUS,
        output SC_GAMESTATUS_TransitionCounter1_InLow,
        output SC_GAMESTATUS_TRANSITIONTIME_InLow,
        input  SC_GAMESTATUS_LifesZero_OutLow,
        input  SC_GAMESTATUS_WIN_OutLow,
        input  SC_GAMESTATUS_TransitionDone_OutLow,
        input  SC_GAMESTATUS_Lives_OutBUS,
        input  SC_GAMESTATUS_Level_OutBUS
    );

    // Tracker side
    modport slave (
        input  SC_GAMESTATUS_CLEAR_InLow,
        input  SC_GAMESTATUS_ClearLost_InLow,
        input  SC_GAMESTATUS_LifesSignal_InBUS,
        input  SC_GAMESTATUS_TransitionCounter1_InLow,
        input  SC_GAMESTATUS_TRANSITIONTIME_InLow,
        output SC_GAMESTATUS_LifesZero_OutLow,
        output SC_GAMESTATUS_WIN_OutLow,
        output SC_GAMESTATUS_TransitionDone_OutLow,
        output SC_GAMESTATUS_Lives_OutBUS,
        output SC_GAMESTATUS_Level_OutBUS
    );
endinterface
`default_nettype wire

// File: rtl/sc_game_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : sc_game_status_tracker
// Purpose  : Datapath partner of the game state machine. Holds lives, level
//            and the inter-level transition timer, and returns the
//            lives-zero / win / transition-done flags the FSM branches on.
// Ports    : SC_GAMESTATUS_CLOCK_50     - clock, rising edge
//            SC_GAMESTATUS_RESET_InHigh - synchronous active-high reset
//            bus (slave modport)        - FSM strobes in, flags/counts out
// Options  : SC_GAMESTATUS_BONUSLIFE_EN - when defined, every level
//            increment landing on a nonzero multiple of BONUS_LEVEL grants
//            one extra life (saturating). Undefined: no bonus logic.
// Revision : 1.0 - initial release
// ============================================================================
module sc_game_status_tracker #(
    parameter int LIFE_W            = 3,
    parameter int INIT_LIVES        = 3,
    parameter int MAX_LIVES         = 7,
    parameter int LEVEL_W           = 3,
    parameter int NUM_LEVELS        = 4,
    parameter int TRANS_W           = 26,
    parameter int TRANSITION_CYCLES = 50_000_000,
    parameter int BONUS_LEVEL       = 2
) (
    input  wire logic                  SC_GAMESTATUS_CLOCK_50,
    input  wire logic                  SC_GAMESTATUS_RESET_InHigh,
    sc_game_status_tracker_if.slave    bus
);

    localparam logic [LIFE_W-1:0]  c_init_lives = LIFE_W'(INIT_LIVES);
    localparam logic [LIFE_W-1:0]  c_max_lives  = LIFE_W'(MAX_LIVES);
    localparam logic [LEVEL_W-1:0] c_level_win  = LEVEL_W'(NUM_LEVELS);
    localparam logic [LEVEL_W-1:0] c_level_sat  = LEVEL_W'(NUM_LEVELS + 1);
    localparam logic [TRANS_W-1:0] c_timer_last = TRANS_W'(TRANSITION_CYCLES - 1);

    // Elaboration-time guard against parameter sets the counters cannot honour.
    generate
        if (MAX_LIVES > (2**LIFE_W - 1) || INIT_LIVES > MAX_LIVES ||
            TRANSITION_CYCLES < 2 || BONUS_LEVEL < 1 ||
            (NUM_LEVELS + 1) > (2**LEVEL_W - 1)) begin : g_bad_params
            $error("sc_game_status_tracker: illegal parameter combination");
        end
    endgenerate

    logic [LIFE_W-1:0]  r_lives;
    logic [LEVEL_W-1:0] r_level;
    logic [TRANS_W-1:0] r_timer;

    logic               w_clear;
    logic               w_inc;
    logic               w_dec;
    logic               w_level_step;
    logic [LEVEL_W-1:0] w_level_next;
    logic               w_bonus;
    logic [1:0]         w_up;
    logic [1:0]         w_net_up;
    logic [LIFE_W+1:0]  w_lives_sum;
    logic [LIFE_W-1:0]  w_lives_next;

    assign w_clear = ~bus.SC_GAMESTATUS_CLEAR_InLow | ~bus.SC_GAMESTATUS_ClearLost_InLow;
    assign w_inc   = (bus.SC_GAMESTATUS_LifesSignal_InBUS == 2'b01);
    assign w_dec   = (bus.SC_GAMESTATUS_LifesSignal_InBUS == 2'b10);

    // Level advances once per low strobe cycle until it reaches the win value.
    assign w_level_step = ~bus.SC_GAMESTATUS_TransitionCounter1_InLow && (r_level != c_level_sat);
    assign w_level_next = w_level_step ? (r_level + LEVEL_W'(1)) : r_level;

`ifdef SC_GAMESTATUS_BONUSLIFE_EN
    // Level after a step is always nonzero, so only the multiple test remains.
    assign w_bonus = w_level_step && ((int'(w_level_next) % BONUS_LEVEL) == 0);
`else
    assign w_bonus = 1'b0;
`endif

    // Bonus and the player's own inc/dec are merged into one net delta so a
    // simultaneous bonus and decrement cancel exactly, and +2 saturates once.
    assign w_up        = {1'b0, w_inc} + {1'b0, w_bonus};
    assign w_net_up    = w_up - {1'b0, w_dec};
    assign w_lives_sum = {2'b00, r_lives} + {{LIFE_W{1'b0}}, w_net_up};

    always_comb begin
        w_lives_next = r_lives;
        if (w_dec && (w_up == 2'd0)) begin
            if (r_lives != '0) begin
                w_lives_next = r_lives - LIFE_W'(1);
            end
        end else if (w_up > {1'b0, w_dec}) begin
            if (w_lives_sum > {2'b00, c_max_lives}) begin
                w_lives_next = c_max_lives;
            end else begin
                w_lives_next = w_lives_sum[LIFE_W-1:0];
            end
        end
    end

    always_ff @(posedge SC_GAMESTATUS_CLOCK_50) begin
        if (SC_GAMESTATUS_RESET_InHigh) begin
            r_lives <= c_init_lives;
            r_level <= '0;
            r_timer <= '0;
        end else begin
            if (w_clear) begin
                r_lives <= c_init_lives;
                r_level <= '0;
            end else begin
                r_lives <= w_lives_next;
                r_level <= w_level_next;
            end

            // Timer holds at its last value while run stays requested so the
            // done flag remains asserted until the FSM releases it.
            if (bus.SC_GAMESTATUS_TRANSITIONTIME_InLow || ~bus.SC_GAMESTATUS_CLEAR_InLow) begin
                r_timer <= '0;
            end else if (r_timer != c_timer_last) begin
                r_timer <= r_timer + TRANS_W'(1);
            end
        end
    end

    assign bus.SC_GAMESTATUS_LifesZero_OutLow      = ~(r_lives == '0);
    assign bus.SC_GAMESTATUS_WIN_OutLow            = ~(r_level > c_level_win);
    assign bus.SC_GAMESTATUS_TransitionDone_OutLow = ~(r_timer == c_timer_last);
    assign bus.SC_GAMESTATUS_Lives_OutBUS          = r_lives;
    assign bus.SC_GAMESTATUS_Level_OutBUS          = r_level;

endmodule
`default_nettype wire

// File: tb/tb_sc_game_status_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_sc_game_status_tracker
// Purpose  : Directed self-checking bench for sc_game_status_tracker with a
//            short transition timer (TRANSITION_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sc_game_status_tracker;

    localparam int LIFE_W  = 3;
    localparam int LEVEL_W = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sc_game_status_tracker_if #(.LIFE_W(LIFE_W), .LEVEL_W(LEVEL_W)) bus ();

    sc_game_status_tracker #(
        .LIFE_W(LIFE_W), .INIT_LIVES(3), .MAX_LIVES(7), .LEVEL_W(LEVEL_W),
        .NUM_LEVELS(4), .TRANS_W(26), .TRANSITION_CYCLES(4), .BONUS_LEVEL(2)
    ) dut (
        .SC_GAMESTATUS_CLOCK_50     (clk),
        .SC_GAMESTATUS_RESET_InHigh (rst),
        .bus                        (bus.slave)
    );

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.SC_GAMESTATUS_CLEAR_InLow            = 1'b1;
        bus.SC_GAMESTATUS_ClearLost_InLow        = 1'b1;
        bus.SC_GAMESTATUS_LifesSignal_InBUS      = 2'b00;
        bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow   = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (bus.SC_GAMESTATUS_Lives_OutBUS !== 3'd3) begin
            n_fail++; $display("FAIL reset_lives got=%0d exp=3", bus.SC_GAMESTATUS_Lives_OutBUS);
        end
        n_checks++;
        if (bus.SC_GAMESTATUS_Level_OutBUS !== 3'd0) begin
            n_fail++; $display("FAIL reset_level got=%0d exp=0", bus.SC_GAMESTATUS_Level_OutBUS);
        end
        n_checks++;
        if ({bus.SC_GAMESTATUS_LifesZero_OutLow, bus.SC_GAMESTATUS_WIN_OutLow,
             bus.SC_GAMESTATUS_TransitionDone_OutLow} !== 3'b111) begin
            n_fail++; $display("FAIL reset_flags got=%b%b%b exp=111",
                bus.SC_GAMESTATUS_LifesZero_OutLow, bus.SC_GAMESTATUS_WIN_OutLow,
                bus.SC_GAMESTATUS_TransitionDone_OutLow);
        end
    endtask

    task automatic test_lives_dec();
        logic [2:0] exp_l [4] = '{3'd2, 3'd1, 3'd0, 3'd0};
        logic       exp_z [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b10;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if (bus.SC_GAMESTATUS_Lives_OutBUS !== exp_l[i]) begin
                n_fail++; $display("FAIL dec_lives[%0d] got=%0d exp=%0d", i,
                    bus.SC_GAMESTATUS_Lives_OutBUS, exp_l[i]);
            end
            n_checks++;
            if (bus.SC_GAMESTATUS_LifesZero_OutLow !== exp_z[i]) begin
                n_fail++; $display("FAIL dec_zero[%0d] got=%b exp=%b", i,
                    bus.SC_GAMESTATUS_LifesZero_OutLow, exp_z[i]);
            end
        end
        bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b00;
    endtask

    task automatic test_lives_inc_sat();
        // From 0: seven increments reach 7, the eighth must saturate.
        bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_checks++;
            if (bus.SC_GAMESTATUS_Lives_OutBUS !== 3'((i > 7) ? 7 : i)) begin
                n_fail++; $display("FAIL inc_lives[%0d] got=%0d exp=%0d", i,
                    bus.SC_GAMESTATUS_Lives_OutBUS, (i > 7) ? 7 : i);
            end
        end
        // Clear-lost outranks a same-edge decrement.
        bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b10;
        bus.SC_GAMESTATUS_ClearLost_InLow   = 1'b0;
        step();
        bus.SC_GAMESTATUS_LifesSignal_InBUS = 2'b00;
        bus.SC_GAMESTATUS_ClearLost_InLow   = 1'b1;
        n_checks++;
        if (bus.SC_GAMESTATUS_Lives_OutBUS !== 3'd3) begin
            n_fail++; $display("FAIL clearlost_lives got=%0d exp=3", bus.SC_GAMESTATUS_Lives_OutBUS);
        end
    endtask

    task automatic test_timer();
        // Timer 0 -> 1,2,3; done (timer==3) after the third running edge.
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step();
            n_checks++;
            if (bus.SC_GAMESTATUS_TransitionDone_OutLow !== ((i >= 3) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL timer_done[%0d] got=%b exp=%b", i,
                    bus.SC_GAMESTATUS_TransitionDone_OutLow, (i >= 3) ? 1'b0 : 1'b1);
            end
        end
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow = 1'b1;
        step();
        n_checks++;
        if (bus.SC_GAMESTATUS_TransitionDone_OutLow !== 1'b1) begin
            n_fail++; $display("FAIL timer_release got=%b exp=1", bus.SC_GAMESTATUS_TransitionDone_OutLow);
        end
        // Restart proves the timer really went back to 0.
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++;
            if (bus.SC_GAMESTATUS_TransitionDone_OutLow !== ((i == 3) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL timer_restart[%0d] got=%b exp=%b", i,
                    bus.SC_GAMESTATUS_TransitionDone_OutLow, (i == 3) ? 1'b0 : 1'b1);
            end
        end
        // CLEAR alone must also zero the timer while run is still requested.
        bus.SC_GAMESTATUS_CLEAR_InLow = 1'b0;
        step();
        bus.SC_GAMESTATUS_CLEAR_InLow = 1'b1;
        n_checks++;
        if (bus.SC_GAMESTATUS_TransitionDone_OutLow !== 1'b1) begin
            n_fail++; $display("FAIL timer_clear got=%b exp=1", bus.SC_GAMESTATUS_TransitionDone_OutLow);
        end
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow = 1'b1;
        step();
    endtask

    task automatic test_level();
        for (int i = 1; i <= 6; i++) begin
            bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b0;
            step();
            bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;
            n_checks++;
            if (bus.SC_GAMESTATUS_Level_OutBUS !== 3'((i > 5) ? 5 : i)) begin
                n_fail++; $display("FAIL level[%0d] got=%0d exp=%0d", i,
                    bus.SC_GAMESTATUS_Level_OutBUS, (i > 5) ? 5 : i);
            end
            n_checks++;
            if (bus.SC_GAMESTATUS_WIN_OutLow !== ((i >= 5) ? 1'b0 : 1'b1)) begin
                n_fail++; $display("FAIL win[%0d] got=%b exp=%b", i,
                    bus.SC_GAMESTATUS_WIN_OutLow, (i >= 5) ? 1'b0 : 1'b1);
            end
            step();
        end
`ifndef SC_GAMESTATUS_BONUSLIFE_EN
        n_checks++;
        if (bus.SC_GAMESTATUS_Lives_OutBUS !== 3'd3) begin
            n_fail++; $display("FAIL level_no_bonus got=%0d exp=3", bus.SC_GAMESTATUS_Lives_OutBUS);
        end
`endif
        bus.SC_GAMESTATUS_CLEAR_InLow = 1'b0;
        step();
        bus.SC_GAMESTATUS_CLEAR_InLow = 1'b1;
        n_checks++;
        if ({bus.SC_GAMESTATUS_Level_OutBUS, bus.SC_GAMESTATUS_WIN_OutLow} !== {3'd0, 1'b1}) begin
            n_fail++; $display("FAIL level_clear got=%0d/%b exp=0/1",
                bus.SC_GAMESTATUS_Level_OutBUS, bus.SC_GAMESTATUS_WIN_OutLow);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] sig   [5] = '{2'b10, 2'b01, 2'b01, 2'b11, 2'b10};
        logic [2:0] exp_l [5] = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd3};
        for (int i = 0; i < 5; i++) begin
            bus.SC_GAMESTATUS_LifesSignal_InBUS = sig[i];
            step();
            n_checks++;
            if (bus.SC_GAMESTATUS_Lives_OutBUS !== exp_l[i]) begin
                n_fail++; $display("FAIL b2b_lives[%0d] got=%0d exp=%0d", i,
                    bus.SC_GAMESTATUS_Lives_OutBUS, exp_l[i]);
            end
        end
        // Reset mid-activity: everything requested on this edge is discarded.
        bus.SC_GAMESTATUS_LifesSignal_InBUS        = 2'b01;
        bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b0;
        bus.SC_GAMESTATUS_TRANSITIONTIME_InLow     = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        n_checks++;
        if ({bus.SC_GAMESTATUS_Lives_OutBUS, bus.SC_GAMESTATUS_Level_OutBUS,
             bus.SC_GAMESTATUS_TransitionDone_OutLow} !== {3'd3, 3'd0, 1'b1}) begin
            n_fail++; $display("FAIL midreset got=%0d/%0d/%b exp=3/0/1",
                bus.SC_GAMESTATUS_Lives_OutBUS, bus.SC_GAMESTATUS_Level_OutBUS,
                bus.SC_GAMESTATUS_TransitionDone_OutLow);
        end
    endtask

`ifdef SC_GAMESTATUS_BONUSLIFE_EN
    task automatic test_bonus();
        // level 1: no bonus; 2: +1; 3: none; 4: bonus cancelled by decrement.
        logic [1:0] sig   [4] = '{2'b00, 2'b00, 2'b00, 2'b10};
        logic [2:0] exp_l [4] = '{3'd3, 3'd4, 3'd4, 3'd4};
        for (int i = 0; i < 4; i++) begin
            bus.SC_GAMESTATUS_LifesSignal_InBUS        = sig[i];
            bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b0;
            step();
            bus.SC_GAMESTATUS_LifesSignal_InBUS        = 2'b00;
            bus.SC_GAMESTATUS_TransitionCounter1_InLow = 1'b1;
            n_checks++;
            if (bus.SC_GAMESTATUS_Lives_OutBUS !== exp_l[i]) begin
                n_fail++; $display("FAIL bonus_lives[%0d] got=%0d exp=%0d", i,
                    bus.SC_GAMESTATUS_Lives_OutBUS, exp_l[i]);
            end
        end
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_lives_dec();
        test_lives_inc_sat();
        test_timer();
        test_level();
        test_back_to_back();
`ifdef SC_GAMESTATUS_BONUSLIFE_EN
        test_bonus();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
